serial_alu: RTL and testbench

Parametrised bit-serial ALU: the multi-bit, handshaked successor to the single-bit state-machine ALU. It accepts two WIDTH-bit operands plus an opcode, then processes one bit per clock, LSB first, through a 1-bit slice. It reports the result with carry, signed-overflow, zero and error flags. It sits as a slow, low-area arithmetic unit behind a simple start/done handshake.

---
 rtl/serial_alu_pkg.sv | 18 +
 rtl/serial_alu_bit_slice.sv | 33 +++
 rtl/serial_alu.sv | 152 +++++++++++++++
 tb/tb_serial_alu.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/serial_alu_pkg.sv
// Shared types for the bit-serial ALU.
// Opcode and FSM state encodings.
package serial_alu_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_ERR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/serial_alu_bit_slice.sv
// Combinational 1-bit ALU slice.
// Reused every RUN cycle by serial_alu.
module alu_bit_slice
  import serial_alu_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic binv,
  input  logic cin,
  input  op_e  op,
  output logic y,
  output logic cout
);

  logic bb;

  assign bb = b ^ binv;

  always_comb begin
    y    = 1'b0;
    cout = 1'b0;
    unique case (op)
      OP_AND: y = a & bb;
      OP_OR:  y = a | bb;
      OP_ADD: begin
        y    = a ^ bb ^ cin;
        cout = (a & bb) | (cin & (a ^ bb));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: one bit per clock, LSB first,
// behind a start/done handshake.
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             binv,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             error
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  op_e              op_q, op_d;
  logic             binv_q, binv_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic s_y;
  logic s_c;

  alu_bit_slice u_slice (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .binv (binv_q),
    .cin  (carry_q),
    .op   (op_q),
    .y    (s_y),
    .cout (s_c)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    op_d    = op_q;
    binv_d  = binv_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op_e'(op);
          binv_d  = binv;
          carry_d = cin;
          cnt_d   = '0;
          sh_d    = '0;
          if (op_e'(op) == OP_ERR) begin
            state_d = DONE;
            y_d     = '0;
            cout_d  = 1'b0;
            ovf_d   = 1'b0;
            zero_d  = 1'b0;
            err_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sh_d    = {s_y, sh_q[WIDTH-1:1]};
        carry_d = s_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          y_d     = sh_d;
          cout_d  = s_c;
          // carry_q is the carry into the MSB here
          ovf_d   = (op_q == OP_ADD) & (carry_q ^ s_c);
          zero_d  = (sh_d == '0);
          err_d   = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      op_q    <= OP_AND;
      binv_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      y_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      op_q    <= op_d;
      binv_q  <= binv_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign y        = y_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign error    = err_q;

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu.
// Directed cases plus random ops vs an arithmetic model.
module tb_serial_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   op = 2'b00;
  logic         binv = 1'b0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] y;
  logic         cout;
  logic         overflow;
  logic         zero;
  logic         error;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] prev_y = '0;

  serial_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .op       (op),
    .binv     (binv),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .y        (y),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero),
    .error    (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       input logic [1:0] mop, input logic mbi,
                       input logic mci, output logic [W-1:0] ey,
                       output logic ec, output logic ev,
                       output logic ez, output logic ee);
    int unsigned bb;
    int unsigned sum;
    bb = mbi ? (~mb & ((1 << W) - 1)) : mb;
    ey = '0; ec = 0; ev = 0; ee = 0;
    case (mop)
      2'b00: ey = W'(ma & bb);
      2'b01: ey = W'(ma | bb);
      2'b10: begin
        sum = ma + bb + mci;
        ey  = W'(sum);
        ec  = (sum >> W) & 1;
        ev  = (ma[W-1] == bb[W-1]) && (ey[W-1] != ma[W-1]);
      end
      default: ee = 1;
    endcase
    ez = !ee && (ey == 0);
  endtask

  task automatic run(input string tag, input logic [W-1:0] ra,
                     input logic [W-1:0] rb, input logic [1:0] rop,
                     input logic rbi, input logic rci, input bit poke);
    logic [W-1:0] ey;
    logic ec, ev, ez, ee;
    int cyc;
    int want;
    model(ra, rb, rop, rbi, rci, ey, ec, ev, ez, ee);
    want = (rop == 2'b11) ? 1 : W + 1;
    @(negedge clk);
    a = ra; b = rb; op = rop; binv = rbi; cin = rci; start = 1;
    @(posedge clk); #1;
    start = 0;
    cyc = 1;
    chk({tag, ".busy"}, 32'(busy), 1);
    if (rop != 2'b11) chk({tag, ".hold"}, 32'(y), 32'(prev_y));
    while (!done && cyc < W + 4) begin
      if (poke && cyc == 2) begin
        start = 1;
        a = W'($urandom); b = W'($urandom); op = 2'($urandom);
      end
      if (cyc == 3) start = 0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 0;
    chk({tag, ".lat"}, 32'(cyc), 32'(want));
    chk({tag, ".y"}, 32'(y), 32'(ey));
    chk({tag, ".cout"}, 32'(cout), 32'(ec));
    chk({tag, ".ovf"}, 32'(overflow), 32'(ev));
    chk({tag, ".zero"}, 32'(zero), 32'(ez));
    chk({tag, ".err"}, 32'(error), 32'(ee));
    @(posedge clk); #1;
    chk({tag, ".idle"}, {30'd0, busy, done}, 0);
    prev_y = ey;
  endtask

  initial begin
    int dn;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.outs", {busy, done, cout, overflow, zero, error}, 0);
    chk("rst.y", 32'(y), 0);
    @(negedge clk);
    reset = 0;

    run("add", 8'h3C, 8'h05, 2'b10, 0, 0, 1);
    run("sub", 8'h05, 8'h05, 2'b10, 1, 1, 0);
    run("ovf", 8'h7F, 8'h01, 2'b10, 0, 0, 0);
    run("wrap", 8'hFF, 8'h01, 2'b10, 0, 0, 1);
    run("and", 8'hF0, 8'hCC, 2'b00, 1, 0, 0);
    run("or", 8'hF0, 8'h0C, 2'b01, 0, 0, 0);
    run("err", 8'h12, 8'h34, 2'b11, 0, 0, 0);
    run("clr", 8'h01, 8'h02, 2'b10, 0, 0, 0);
    run("neg", 8'h80, 8'h01, 2'b10, 1, 1, 0);

    for (int i = 0; i < 24; i++)
      run("rnd", W'($urandom), W'($urandom), 2'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom));

    @(negedge clk);
    a = 8'h55; b = 8'h22; op = 2'b10; binv = 0; cin = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1;
    #1;
    chk("mid.outs", {busy, done, cout, overflow, zero, error}, 0);
    chk("mid.y", 32'(y), 0);
    @(negedge clk);
    reset = 0;
    dn = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("mid.nodone", 32'(dn), 0);
    prev_y = '0;
    run("post", 8'h10, 8'h20, 2'b10, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1, "timeout");
  end

endmodule
